// File: rtl/cookie_scoreboard.sv
// PacMan cookie scoreboard: counts eaten cookies, tracks score and remaining count, and sequences level clear/respawn.
// Optional power-cookie scoring and power mode are compiled in with `define POWER_COOKIE_EN.
module cookie_scoreboard #(
  parameter int                     NUM_COOKIES  = 64,
  parameter int                     POINTS       = 10,
  parameter int                     CLEAR_FRAMES = 120,
  parameter logic [NUM_COOKIES-1:0] POWER_MASK   = '0,
  parameter int                     POWER_POINTS = 50,
  parameter int                     POWER_FRAMES = 360
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic [NUM_COOKIES-1:0]               Not_ate,
  input  logic                                 Frame_tick,
  output logic [15:0]                          Score,
  output logic [$clog2(NUM_COOKIES+1)-1:0]     Remaining,
  output logic [3:0]                           Level,
  output logic                                 Level_clear,
  output logic                                 Cookie_reset,
  output logic                                 Power_mode
);

  localparam int RW = $clog2(NUM_COOKIES + 1);
  localparam int CW = $clog2(CLEAR_FRAMES + 2);

  typedef enum logic [1:0] {LOAD, PLAY, CLEAR_HOLD, RESPAWN} state_t;

  state_t                 state;
  logic                   load_cnt;
  logic [NUM_COOKIES-1:0] prev;
  logic [CW-1:0]          clr_cnt;

  logic [NUM_COOKIES-1:0] eaten;
  logic [RW-1:0]          n_tot;
  logic [RW-1:0]          n_pow;
  logic [31:0]            add;
  logic [RW-1:0]          rem_next;
  logic                   scoring;
  logic                   enter_clear;

  function automatic logic [RW-1:0] popcount(input logic [NUM_COOKIES-1:0] v);
    logic [RW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_COOKIES; i++) c = c + RW'(v[i]);
    return c;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] base, input logic [31:0] inc);
    logic [32:0] sum;
    sum = {17'd0, base} + {1'b0, inc};
    return (sum[32:16] != '0) ? 16'hFFFF : sum[15:0];
  endfunction

  always_comb begin
    eaten       = prev & ~Not_ate;
    n_tot       = popcount(eaten);
    scoring     = (state == PLAY) && (Remaining != '0);
    enter_clear = (state == PLAY) && (Remaining == '0);
    rem_next    = (n_tot >= Remaining) ? '0 : Remaining - n_tot;
`ifdef POWER_COOKIE_EN
    n_pow = popcount(eaten & POWER_MASK);
    add   = 32'(n_tot - n_pow) * 32'(POINTS) + 32'(n_pow) * 32'(POWER_POINTS);
`else
    n_pow = '0;
    add   = 32'(n_tot) * 32'(POINTS);
`endif
  end

  // Level sequencer: settle, play, clear banner, one-cycle respawn
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= LOAD;
      load_cnt     <= 1'b0;
      prev         <= '1;
      clr_cnt      <= '0;
      Score        <= '0;
      Remaining    <= '0;
      Level        <= 4'd1;
      Level_clear  <= 1'b0;
      Cookie_reset <= 1'b0;
    end else begin
      Cookie_reset <= 1'b0;
      case (state)
        LOAD: begin
          if (load_cnt) begin
            Remaining <= popcount(Not_ate);
            prev      <= Not_ate;
            load_cnt  <= 1'b0;
            state     <= PLAY;
          end else begin
            load_cnt <= 1'b1;
          end
        end
        PLAY: begin
          prev <= Not_ate;
          if (enter_clear) begin
            Level_clear <= 1'b1;
            clr_cnt     <= '0;
            state       <= CLEAR_HOLD;
          end else begin
            Score     <= sat16(Score, add);
            Remaining <= rem_next;
          end
        end
        CLEAR_HOLD: begin
          if ((32'(clr_cnt) + 32'(Frame_tick)) >= 32'(CLEAR_FRAMES)) begin
            Level_clear  <= 1'b0;
            Cookie_reset <= 1'b1;
            state        <= RESPAWN;
          end else begin
            clr_cnt <= clr_cnt + CW'(Frame_tick);
          end
        end
        RESPAWN: begin
          if (Level != 4'd15) Level <= Level + 4'd1;
          load_cnt <= 1'b0;
          state    <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef POWER_COOKIE_EN
  localparam int PW = $clog2(POWER_FRAMES + 2);
  logic [PW-1:0] pwr_cnt;

  // A fresh power cookie always restarts the full period, even on a tick cycle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Power_mode <= 1'b0;
      pwr_cnt    <= '0;
    end else if (enter_clear) begin
      Power_mode <= 1'b0;
      pwr_cnt    <= '0;
    end else if (scoring && (n_pow != '0)) begin
      Power_mode <= (POWER_FRAMES != 0);
      pwr_cnt    <= PW'(POWER_FRAMES);
    end else if (Power_mode && Frame_tick) begin
      pwr_cnt <= pwr_cnt - PW'(1);
      if (pwr_cnt == PW'(1)) Power_mode <= 1'b0;
    end
  end
`else
  logic unused_power_cfg;
  assign unused_power_cfg = ^{POWER_MASK, 32'(POWER_POINTS), 32'(POWER_FRAMES), n_pow};
  assign Power_mode = 1'b0;
`endif

endmodule

// File: tb/tb_cookie_scoreboard.sv
// Directed bench for cookie_scoreboard with an abstract per-cycle reference model and hand-computed pins.
module tb_cookie_scoreboard;

  localparam int N    = 8;
  localparam int PTS  = 10;
  localparam int CF   = 3;
  localparam logic [7:0] PMASK = 8'h01;
  localparam int PPTS = 50;
  localparam int PF   = 2;
`ifdef POWER_COOKIE_EN
  localparam bit PWR_EN = 1'b1;
`else
  localparam bit PWR_EN = 1'b0;
`endif

  localparam int PH_LOAD = 0, PH_PLAY = 1, PH_HOLD = 2, PH_RESP = 3;

  logic       Clk = 1'b0;
  logic       rst;
  logic [7:0] na;
  logic       ft;
  logic [15:0] Score;
  logic [3:0]  Remaining;
  logic [3:0]  Level;
  logic        Level_clear;
  logic        Cookie_reset;
  logic        Power_mode;

  int n_chk = 0;
  int n_fail = 0;

  cookie_scoreboard #(
    .NUM_COOKIES(N), .POINTS(PTS), .CLEAR_FRAMES(CF),
    .POWER_MASK(PMASK), .POWER_POINTS(PPTS), .POWER_FRAMES(PF)
  ) dut (
    .Clk(Clk), .Reset(rst), .Not_ate(na), .Frame_tick(ft),
    .Score(Score), .Remaining(Remaining), .Level(Level),
    .Level_clear(Level_clear), .Cookie_reset(Cookie_reset), .Power_mode(Power_mode)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int phase; int settle; logic [7:0] prev;
    int score; int rem; int level;
    int clear; int creset; int pleft; int frames;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.phase = PH_LOAD; r.settle = 0; r.prev = 8'hFF;
    r.score = 0; r.rem = 0; r.level = 1;
    r.clear = 0; r.creset = 0; r.pleft = 0; r.frames = 0;
    return r;
  endfunction

  function automatic model_t model_step(model_t cur, logic [7:0] nav, logic tk);
    model_t r;
    logic [7:0] eaten;
    int n, np;
    bool_reload: begin end
    r = cur;
    r.creset = 0;
    if (cur.pleft > 0 && tk) r.pleft = cur.pleft - 1;
    case (cur.phase)
      PH_LOAD: begin
        if (cur.settle == 1) begin
          r.rem = $countones(nav); r.prev = nav; r.settle = 0; r.phase = PH_PLAY;
        end else r.settle = 1;
      end
      PH_PLAY: begin
        r.prev = nav;
        if (cur.rem == 0) begin
          r.phase = PH_HOLD; r.clear = 1; r.frames = 0; r.pleft = 0;
        end else begin
          eaten = cur.prev & ~nav;
          n  = $countones(eaten);
          np = PWR_EN ? $countones(eaten & PMASK) : 0;
          r.score = cur.score + (n - np) * PTS + np * PPTS;
          if (r.score > 65535) r.score = 65535;
          r.rem = (cur.rem > n) ? cur.rem - n : 0;
          if (np > 0) r.pleft = PF;
        end
      end
      PH_HOLD: begin
        if (tk) r.frames = cur.frames + 1;
        if (r.frames >= CF) begin r.phase = PH_RESP; r.clear = 0; r.creset = 1; end
      end
      default: begin
        r.level = (cur.level < 15) ? cur.level + 1 : 15;
        r.phase = PH_LOAD; r.settle = 0;
      end
    endcase
    return r;
  endfunction

  always @(posedge Clk) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, na, ft);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare every output against the model
  task automatic tick();
    @(negedge Clk);
    chk("m_score", Score, m.score);
    chk("m_remaining", Remaining, m.rem);
    chk("m_level", Level, m.level);
    chk("m_level_clear", Level_clear, m.clear);
    chk("m_cookie_reset", Cookie_reset, m.creset);
    chk("m_power_mode", Power_mode, (m.pleft > 0) ? 1 : 0);
  endtask

  task automatic run_level();
    bit seen;
    seen = 1'b0;
    tick(); tick();
    na = 8'h00; tick(); tick();
    ft = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Cookie_reset === 1'b1) begin seen = 1'b1; break; end
    end
    chk("lvl_creset_seen", seen, 1);
    ft = 1'b0; na = 8'hFF; tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int lv;
    rst = 1'b1; na = 8'hFF; ft = 1'b0;
    tick(); tick();
    chk("rst_score", Score, 0);
    chk("rst_level", Level, 1);
    chk("rst_remaining", Remaining, 0);
    chk("rst_clear", Level_clear, 0);

    rst = 1'b0;
    tick();
    chk("load_wait_rem", Remaining, 0);
    tick();
    chk("load_rem", Remaining, 8);

    na = 8'hF7; tick();
    chk("eat1_score", Score, 10);
    chk("eat1_rem", Remaining, 7);
    na = 8'h96; tick();
    chk("eat3_score", Score, PWR_EN ? 80 : 40);
    chk("eat3_rem", Remaining, 4);
    na = 8'h9E; tick();
    chk("rise_score", Score, PWR_EN ? 80 : 40);
    chk("rise_rem", Remaining, 4);
    na = 8'h00; tick();
    chk("floor_score", Score, PWR_EN ? 130 : 90);
    chk("floor_rem", Remaining, 0);
    tick();
    chk("clear_on", Level_clear, 1);

    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ft = (i % 2 == 1);
      tick();
      if (Cookie_reset === 1'b1) begin seen = 1'b1; break; end
    end
    chk("creset_seen", seen, 1);
    chk("resp_clear", Level_clear, 0);
    na = 8'hFF; ft = 1'b0; tick();
    chk("level2", Level, 2);
    chk("creset_once", Cookie_reset, 0);
    tick(); tick();
    chk("reload_rem", Remaining, 8);
    chk("kept_score", Score, PWR_EN ? 130 : 90);

    na = 8'h00; tick(); tick();
    chk("hold2_clear", Level_clear, 1);
    ft = 1'b1; tick();
    ft = 1'b0; rst = 1'b1; tick();
    chk("mid_rst_clear", Level_clear, 0);
    chk("mid_rst_score", Score, 0);
    chk("mid_rst_level", Level, 1);
    chk("mid_rst_creset", Cookie_reset, 0);
    ft = 1'b1; tick();
    chk("rst_hold_creset", Cookie_reset, 0);
    rst = 1'b0; ft = 1'b0; na = 8'hFF; tick(); tick();
    chk("post_rst_rem", Remaining, 8);

    na = 8'hFE; tick();
    chk("pwr_score1", Score, PWR_EN ? 50 : 10);
    chk("pwr_on", Power_mode, PWR_EN);
    ft = 1'b1; tick();
    chk("pwr_after1", Power_mode, PWR_EN);
    ft = 1'b0; na = 8'hFF; tick();
    na = 8'hFE; tick();
    chk("pwr_score2", Score, PWR_EN ? 100 : 20);
    ft = 1'b1; tick();
    chk("pwr_ext1", Power_mode, PWR_EN);
    tick();
    chk("pwr_off", Power_mode, 0);
    ft = 1'b0;

    rst = 1'b1; na = 8'hFF; tick();
    rst = 1'b0;
    lv = 0;
    while (m.score < 65520 && lv < 1000) begin
      run_level();
      lv++;
    end
    chk("pre_sat_score", Score, 65520);
    chk("level_sat", Level, 15);
    tick(); tick();
    na = 8'hFC; tick();
    chk("sat_score", Score, 16'hFFFF);
    chk("sat_rem", Remaining, 6);
    na = 8'h00; tick();
    chk("sat_hold", Score, 16'hFFFF);
    chk("sat_rem0", Remaining, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
